pipe_rx_buffer: RTL and testbench

Receive-side buffer for fixed-latency, non-stallable pipelines built from `delay_fifo` stages.
- The producer launches an item into the pipeline only when `issue_ok` is high.
- Items emerge from the pipeline some cycles later on `in_valid`/`in_data`. This block captures them into a FIFO and presents them to a downstream consumer with ready/valid backpressure.
- A credit counter guarantees that every launched item has a reserved slot, so the pipeline never needs to stall.

---
 rtl/pipe_rx_buffer.sv | 79 +++++++
 tb/tb_pipe_rx_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rx_buffer.sv
// Receive buffer for a fixed-latency, non-stallable pipeline. Each launched item
// holds a reserved FIFO slot through a credit, so the pipeline never has to stall.
module pipe_rx_buffer #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 8,
  parameter int CW       = $clog2(DEPTH+1)
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ok,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic [BITWIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       count,
  output logic [CW-1:0]       credits,
  output logic                overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [BITWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       wp;
  logic [AW-1:0]       rp;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       credits_q;
  logic                overflow_q;
  logic                issue;
  logic                pop;
  logic                full;
  logic                push_ok;

  assign issue_ok  = (credits_q != '0) & ~reset;
  assign issue     = issue_valid & issue_ok;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count_q == CW'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = in_valid & (~full | pop);

  assign out_data = mem[rp];
  assign count    = count_q;
  assign credits  = credits_q;
  assign overflow = overflow_q;

  always_ff @(posedge aclk) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      count_q    <= '0;
      credits_q  <= CW'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop)     rp <= rp + AW'(1);

      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      case ({issue, pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: credits_q <= credits_q;
      endcase

      if (in_valid & ~push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) mem[wp] <= in_data;
  end

endmodule

// File: tb/tb_pipe_rx_buffer.sv
// Bench for pipe_rx_buffer: a 3-stage delay pipeline feeds the buffer, and a
// queue-based reference model tracks FIFO contents, credits and the overflow flag.
module tb_pipe_rx_buffer;

  localparam int BW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ok;
  logic [BW-1:0] issue_data = '0;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic [CW-1:0] credits;
  logic          overflow;
  logic          force_valid = 1'b0;
  logic [BW-1:0] force_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  pipe_rx_buffer #(.BITWIDTH(BW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .reset(reset), .issue_valid(issue_valid), .issue_ok(issue_ok),
    .in_data(in_data), .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .credits(credits), .overflow(overflow)
  );

  // Upstream delay pipeline, three stages, flushed by reset.
  logic [2:0]    pv;
  logic [BW-1:0] pd [3];
  always_ff @(posedge aclk) begin
    if (reset) pv <= '0;
    else       pv <= {pv[1:0], issue_valid & issue_ok};
    pd[0] <= issue_data;
    pd[1] <= pd[0];
    pd[2] <= pd[1];
  end
  assign in_valid = pv[2] | force_valid;
  assign in_data  = force_valid ? force_data : pd[2];

  // Reference model: FIFO as a queue, credits as an integer.
  logic [BW-1:0] q [$];
  int            credits_m = DEPTH;
  bit            ovf_m = 1'b0;
  always @(posedge aclk) begin : ref_model
    bit m_pop, m_iss;
    if (reset) begin
      q.delete();
      credits_m = DEPTH;
      ovf_m = 1'b0;
    end else begin
      m_pop = out_ready && (q.size() > 0);
      m_iss = issue_valid && (credits_m > 0);
      if (m_pop) void'(q.pop_front());
      if (in_valid) begin
        if (q.size() == DEPTH) ovf_m = 1'b1;
        else q.push_back(in_data);
      end
      credits_m = credits_m + int'(m_pop) - int'(m_iss);
    end
  end

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic test_reset();
    reset = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; force_valid = 1'b0;
    tick(); tick();
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL reset_issue_ok_low got %0b want 0", issue_ok); end
    reset = 1'b0;
    tick();
    checks++; if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL reset_credits got %0d want %0d", credits, DEPTH); end
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL reset_issue_ok got %0b want 1", issue_ok); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1; issue_data = BW'(32'h11 + i);
      tick();
    end
    issue_valid = 1'b0;
    checks++; if (credits !== '0) begin errors++; $display("FAIL fill_credits got %0d want 0", credits); end
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL fill_issue_ok got %0b want 0", issue_ok); end
    tick(); tick(); tick();
    checks++; if (count !== CW'(8)) begin errors++; $display("FAIL fill_count got %0d want 8", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== BW'(32'h11 + i)) begin
        errors++; $display("FAIL drain_item%0d got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, 32'h11 + i);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", out_valid); end
    checks++; if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL drain_credits got %0d want %0d", credits, DEPTH); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [BW-1:0] base;
    int issued = 0, received = 0, gaps = 0, cyc = 0;
    bit credit_seen = 1'b0;
    base = BW'($urandom);
    out_ready = 1'b1;
    while (cyc < 250 && received < 100) begin
      if (out_valid) begin
        checks++;
        if (out_data !== base + BW'(received)) begin
          errors++; $display("FAIL stream_item%0d got %h want %h", received, out_data, base + BW'(received));
        end
        received++;
        if (received == 50) begin
          credit_seen = 1'b1;
          checks++; if (credits !== CW'(DEPTH - 3 - 1)) begin errors++; $display("FAIL stream_credits got %0d want %0d", credits, DEPTH - 4); end
        end
      end else if (received > 0) gaps++;
      issue_valid = (issued < 100);
      issue_data  = base + BW'(issued);
      if (issue_valid && issue_ok) issued++;
      tick();
      cyc++;
    end
    issue_valid = 1'b0;
    checks++; if (received != 100) begin errors++; $display("FAIL stream_timeout got %0d items want 100", received); end
    checks++; if (gaps != 0 || !credit_seen) begin errors++; $display("FAIL stream_gaps got %0d want 0", gaps); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow got %0b want 0", overflow); end
    tick();
    out_ready = 1'b0;
  endtask

  logic [BW-1:0] exp_after [8];

  task automatic test_full_push_pop();
    logic [BW-1:0] vals [8];
    logic [BW-1:0] f1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vals[i] = BW'($urandom);
      issue_valid = 1'b1; issue_data = vals[i];
      tick();
    end
    issue_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (count !== CW'(8)) begin errors++; $display("FAIL fpp_fill_count got %0d want 8", count); end
    f1 = BW'($urandom);
    out_ready = 1'b1; force_valid = 1'b1; force_data = f1;
    tick();
    out_ready = 1'b0; force_valid = 1'b0;
    checks++; if (count !== CW'(8)) begin errors++; $display("FAIL fpp_count got %0d want 8", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %0b want 0", overflow); end
    checks++; if (out_data !== vals[1]) begin errors++; $display("FAIL fpp_head got %h want %h", out_data, vals[1]); end
    for (int i = 0; i < 7; i++) exp_after[i] = vals[i+1];
    exp_after[7] = f1;
  endtask

  task automatic test_overflow();
    force_valid = 1'b1; force_data = BW'($urandom); out_ready = 1'b0;
    tick();
    force_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
    checks++; if (count !== CW'(8)) begin errors++; $display("FAIL ovf_count got %0d want 8", count); end
    tick(); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data !== exp_after[i]) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", i, out_data, exp_after[i]); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    reset = 1'b1; tick(); reset = 1'b0; tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
    checks++; if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_reset_credits got %0d want %0d", credits, DEPTH); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      issue_valid = 1'b1; issue_data = BW'($urandom);
      tick();
    end
    issue_valid = 1'b0;
    tick();
    checks++; if (count !== CW'(5) || credits !== CW'(1)) begin errors++; $display("FAIL mid_setup got count=%0d credits=%0d want 5 1", count, credits); end
    reset = 1'b1;
    tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
    checks++; if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL mid_credits got %0d want %0d", credits, DEPTH); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %0b want 0", out_valid); end
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL mid_issue_ok_in_reset got %0b want 0", issue_ok); end
    reset = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL mid_issue_ok_after got %0b want 1", issue_ok); end
    checks++; if (count !== '0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_flushed got count=%0d ovf=%0b want 0 0", count, overflow); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if (count !== CW'(q.size()) || credits !== CW'(credits_m) || overflow !== ovf_m ||
          out_valid !== (q.size() != 0) || issue_ok !== (credits_m != 0) ||
          (q.size() != 0 && out_data !== q[0])) begin
        errors++;
        $display("FAIL rand_cyc%0d got cnt=%0d cr=%0d ov=%0b v=%0b ok=%0b want cnt=%0d cr=%0d ov=%0b",
                 cyc, count, credits, overflow, out_valid, issue_ok, q.size(), credits_m, ovf_m);
      end
      checks++;
      if (int'(credits) + int'(count) + $countones(pv) != DEPTH) begin
        errors++; $display("FAIL rand_invariant got %0d want %0d", int'(credits) + int'(count) + $countones(pv), DEPTH);
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_data  = BW'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    issue_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    checks++; if (credits !== CW'(DEPTH) || count !== '0) begin errors++; $display("FAIL rand_settle got cr=%0d cnt=%0d want %0d 0", credits, count, DEPTH); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_full_push_pop();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
